// File: rtl/hazard_ctrl.sv
// Pipeline hazard/control unit: load-use bubbles, taken-branch squash and
// data-memory wait freezing, plus a stall-cycle counter and a sticky timeout flag.
module hazard_ctrl #(
  parameter int REG_ADDR_W   = 5,
  parameter int WAIT_TIMEOUT = 16,
  parameter int CNT_W        = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_stall,
  output logic                  ifid_stall,
  output logic                  ifid_flush,
  output logic                  idex_stall,
  output logic                  idex_flush,
  output logic                  exmem_stall,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic                  state_dbg
);

  localparam int WCW = $clog2(WAIT_TIMEOUT) + 1;

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  state_t         state, state_nxt;
  logic [WCW-1:0] wait_cnt, wait_cnt_nxt;
  logic           timeout_set;
  logic           lu;

  // Data-memory handshake: the MEM stage holds mem_req high until the cycle
  // in which mem_ready is high; that cycle completes the access. A request
  // without ready in the same cycle freezes the pipe from that cycle onward.
  assign lu = ex_mem_read && (ex_rt != '0) &&
              ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  assign state_dbg = state;

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    timeout_set  = 1'b0;
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    ifid_flush   = 1'b0;
    idex_stall   = 1'b0;
    idex_flush   = 1'b0;
    exmem_stall  = 1'b0;
    if (!reset) begin
      case (state)
        RUN: begin
          if (mem_req && !mem_ready) begin
            pc_stall     = 1'b1;
            ifid_stall   = 1'b1;
            idex_stall   = 1'b1;
            exmem_stall  = 1'b1;
            state_nxt    = MEM_WAIT;
            wait_cnt_nxt = WCW'(1);
          end else if (branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (lu) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
          end
        end
        MEM_WAIT: begin
          // EX is frozen, so a branch resolved here re-presents itself in RUN.
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          idex_stall  = 1'b1;
          exmem_stall = 1'b1;
          if (mem_ready) begin
            state_nxt    = RUN;
            wait_cnt_nxt = '0;
          end else if (wait_cnt == WCW'(WAIT_TIMEOUT - 1)) begin
            timeout_set  = 1'b1;
            state_nxt    = RUN;
            wait_cnt_nxt = '0;
          end else begin
            wait_cnt_nxt = wait_cnt + 1'b1;
          end
        end
        default: begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_timeout  <= 1'b0;
      stall_cycles <= '0;
    end else begin
      if (timeout_set)
        mem_timeout <= 1'b1;
      if (pc_stall && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with small timeout and counter widths so
// timeout and saturation are reachable in a short run.
module tb_hazard_ctrl;

  localparam int RW = 5;

  logic          clock;
  logic          reset;
  logic [RW-1:0] id_rs, id_rt, ex_rt;
  logic          id_uses_rt, ex_mem_read, branch_taken, mem_req, mem_ready;
  logic          pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall;
  logic          mem_timeout;
  logic [3:0]    stall_cycles;
  logic          state_dbg;

  int checks   = 0;
  int failures = 0;

  // ctrl vector order: {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall}
  localparam logic [5:0] C_NONE  = 6'b000000;
  localparam logic [5:0] C_LU    = 6'b110010;
  localparam logic [5:0] C_BR    = 6'b001010;
  localparam logic [5:0] C_FRZ   = 6'b110101;

  logic [5:0] exp_q[$];

  hazard_ctrl #(.REG_ADDR_W(RW), .WAIT_TIMEOUT(4), .CNT_W(4)) dut (
    .clock(clock), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_stall(idex_stall), .idex_flush(idex_flush), .exmem_stall(exmem_stall),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .state_dbg(state_dbg)
  );

  // clock/reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // driver tasks
  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; ex_rt = '0;
    id_uses_rt = 1'b0; ex_mem_read = 1'b0; branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard for control vectors
  task automatic chk_ctrl(input string tag, input logic [5:0] exp);
    logic [5:0] e;
    exp_q.push_back(exp);
    #1;
    e = exp_q.pop_front();
    chk(tag, {26'd0, pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall},
        {26'd0, e});
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
    chk_ctrl("reset_ctrl", C_NONE);
    chk("reset_cnt", 32'(stall_cycles), 32'd0);
    chk("reset_to", 32'(mem_timeout), 32'd0);

    // load-use via rs
    ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    chk_ctrl("lu_rs", C_LU);
    cyc();
    chk("lu_cnt", 32'(stall_cycles), 32'd1);
    ex_mem_read = 1'b0;
    chk_ctrl("lu_gone", C_NONE);
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    chk_ctrl("lu_r0", C_NONE);
    ex_rt = 5'd5; id_rs = 5'd3; id_rt = 5'd5; id_uses_rt = 1'b0;
    chk_ctrl("lu_rt_unused", C_NONE);
    id_uses_rt = 1'b1;
    chk_ctrl("lu_rt_used", C_LU);
    cyc();
    chk("lu_rt_cnt", 32'(stall_cycles), 32'd2);

    // branch beats load-use
    branch_taken = 1'b1;
    chk_ctrl("br_over_lu", C_BR);
    cyc();
    chk("br_cnt", 32'(stall_cycles), 32'd2);
    clear_inputs();

    // memory wait with ready on the 4th cycle, branch pending meanwhile
    mem_req = 1'b1;
    chk_ctrl("mw_c0", C_FRZ);
    cyc();
    chk("mw_state", 32'(state_dbg), 32'd1);
    branch_taken = 1'b1;
    chk_ctrl("mw_c1", C_FRZ);
    cyc();
    chk_ctrl("mw_c2", C_FRZ);
    cyc();
    mem_ready = 1'b1;
    chk_ctrl("mw_c3", C_FRZ);
    cyc();
    mem_req = 1'b0; mem_ready = 1'b0;
    chk("mw_run", 32'(state_dbg), 32'd0);
    chk_ctrl("mw_br_after", C_BR);
    chk("mw_cnt", 32'(stall_cycles), 32'd6);
    chk("mw_no_to", 32'(mem_timeout), 32'd0);
    cyc();
    clear_inputs();

    // timeout after 4 stall cycles
    mem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_ctrl($sformatf("to_c%0d", i), C_FRZ);
      cyc();
    end
    chk("to_flag", 32'(mem_timeout), 32'd1);
    chk("to_state", 32'(state_dbg), 32'd0);
    chk("to_cnt", 32'(stall_cycles), 32'd10);
    mem_req = 1'b0;
    chk_ctrl("to_idle", C_NONE);
    repeat (3) cyc();
    chk("to_sticky", 32'(mem_timeout), 32'd1);

    // async reset mid-MEM_WAIT
    mem_req = 1'b1;
    cyc();
    chk("rst_pre_state", 32'(state_dbg), 32'd1);
    #2 reset = 1'b1;
    chk_ctrl("rst_async_ctrl", C_NONE);
    chk("rst_async_cnt", 32'(stall_cycles), 32'd0);
    chk("rst_async_to", 32'(mem_timeout), 32'd0);
    chk("rst_async_state", 32'(state_dbg), 32'd0);
    cyc();
    reset = 1'b0;
    chk("rst_rel_state", 32'(state_dbg), 32'd0);
    chk_ctrl("rst_rel_ctrl", C_FRZ);

    // 20 consecutive stall cycles saturate the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk($sformatf("sat_%0d", i), 32'(stall_cycles), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
    end
    chk("sat_to", 32'(mem_timeout), 32'd1);
    clear_inputs();
    cyc();
    chk("sat_hold", 32'(stall_cycles), 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
